eth_rx_frame_buffer: RTL
========================

# eth_rx_frame_buffer

Store-and-forward receive buffer between the 10GbE MAC receive AXI-Stream (64-bit, from the Alveo MAC/PHY wrapper) and the receive input of the ethernet DMA core. Whole frames are written into an internal RAM. A frame is released downstream only after its last beat arrives error-free. Frames flagged bad by the MAC, and frames that overflow the buffer, are discarded in full, so the DMA never sees a partial or corrupt frame and the MAC never sees backpressure.

## Interface

Parameters:
- `DEPTH`, 512, buffer depth in 64-bit words; must be a power of two, ≥ 256 (one 1518-byte frame is 190 words).
- `CNT_W`, 32, width of the statistics counters.

Ports:
- `clock`  in  1  single clock for all logic.
- `async_resetn`  in  1  asynchronous, active-low reset.
- `s_axis_tdata`  in  64  MAC receive data; byte 0 is `[7:0]`.
- `s_axis_tkeep`  in  8  byte enables.
- `s_axis_tlast`  in  1  last beat of frame.
- `s_axis_tuser`  in  1  bad-frame flag; sampled only on the `tlast` beat.
- `s_axis_tvalid`  in  1  beat valid.
- `s_axis_tready`  out  1  tied to 1; the MAC is never stalled.
- `m_axis_tdata`  out  64  data to the DMA.
- `m_axis_tkeep`  out  8  byte enables.
- `m_axis_tlast`  out  1  last beat of frame.
- `m_axis_tuser`  out  1  constant 0.
- `m_axis_tvalid`  out  1  beat valid.
- `m_axis_tready`  in  1  DMA accept.
- `local_mac`  in  48  station address, byte 0 in `[7:0]`; used only with the filter.
- `promisc`  in  1  accept all destination addresses; used only with the filter.
- `frames_ok`  out  CNT_W  frames committed; saturating.
- `frames_dropped`  out  CNT_W  frames discarded; saturating.
- `drop_pulse`  out  1  one-cycle pulse per discarded frame.

## Operation

**Storage**
- RAM is `DEPTH` × 73 bits, holding `{tlast, tkeep, tdata}`.
- Three pointers, each `log2(DEPTH)+1` bits and wrapping naturally:
  - `wr_ptr`: next write location.
  - `wr_commit`: end of the last good frame.
  - `rd_ptr`: next read location.
- Full condition: `wr_ptr - rd_ptr == DEPTH`.
- Data available: `rd_ptr != wr_commit`.

**Write state machine**
- `IDLE`: the first valid beat starts a frame.
  - Go to `RECV`, or to `DROP` if the buffer is full.
  - If that first beat also has `tlast` set, resolve the frame in the same cycle.
- `RECV`: each valid beat is written and `wr_ptr` increments.
  - Beat arrives while full: go to `DROP` and do not write the beat.
  - `tlast` beat with `tuser=0` (and the filter passes): write the beat, set `wr_commit` to the new `wr_ptr`, increment `frames_ok`, go to `IDLE`.
  - `tlast` beat with `tuser=1`: set `wr_ptr` back to `wr_commit`, increment `frames_dropped`, pulse `drop_pulse`, go to `IDLE`.
- `DROP`: beats are discarded.
  - On `tlast`: set `wr_ptr` back to `wr_commit`, increment `frames_dropped`, pulse `drop_pulse`, go to `IDLE`.

**Read path**
- A registered output stage with a one-entry skid buffer. RAM read latency is 1 cycle.
- `m_axis_tvalid` stays high until the beat is accepted.
- While `tvalid && !tready`, `tdata`, `tkeep` and `tlast` are held stable.
- Reads never pass `wr_commit`.

**Counters**
- Both counters saturate at all-ones and never wrap.

**Simultaneous events**
- A read freeing space in the same cycle as a write: the full check uses `rd_ptr` before the read, which is conservative.
- Commit and read in the same cycle: both take effect.

**Reset**
- Asserting `async_resetn` low mid-frame discards all buffered and partially received frames.
- After reset the block is in `IDLE`.
- An input frame already in progress when reset is released is treated as a new frame starting from the next beat.

## Timing

- Reset values:
  - `m_axis_tvalid`=0, `m_axis_tdata`=0, `m_axis_tkeep`=0, `m_axis_tlast`=0, `m_axis_tuser`=0.
  - `frames_ok`=0, `frames_dropped`=0, `drop_pulse`=0.
  - All pointers 0; write state `IDLE`.
  - `s_axis_tready` is 1 at all times, including during reset.
- Latency: an input `tlast` beat accepted at edge T is committed at T+1, and the first beat of that frame shows `m_axis_tvalid=1` after edge T+3 at the latest (when the output is idle).
- Throughput: 1 beat/cycle in, and 1 beat/cycle out with `m_axis_tready` held high. There are no bubbles between back-to-back frames.
- `drop_pulse` and counter updates are registered: they are visible in the cycle after the `tlast` beat.

## Configuration

- `ETH_RX_MAC_FILTER_EN` defined:
  - On the first beat of a frame, compare `tdata[47:0]` with `local_mac` and with `48'hFFFF_FFFF_FFFF`.
  - A frame is accepted if either comparison matches or `promisc`=1.
  - A mismatching frame enters `DROP` immediately and its first beat is not written.
  - Filtered frames count in `frames_dropped` and pulse `drop_pulse`.
- Macro not defined:
  - `local_mac` and `promisc` are ignored.
  - All error-free, non-overflowing frames pass.

## Test plan

- Good frame: 8-beat frame (60 bytes, last `tkeep`=`8'h0F`, `tuser`=0) with `m_axis_tready`=1 → the same 8 beats appear in order with the same `tkeep`/`tlast`; `frames_ok`=1; first `tvalid` within 3 cycles of the input `tlast`.
- Bad frame then good frame: 10-beat frame with `tuser`=1 on `tlast`, then a 4-beat good frame → only the 4-beat frame appears; `frames_dropped`=1; one `drop_pulse`.
- Overflow: `DEPTH`=256, `m_axis_tready`=0, 300-beat frame → dropped; a following 4-beat frame commits; after raising `tready`, only those 4 beats appear.
- Backpressure: three back-to-back 5-beat frames with `m_axis_tready` toggling every cycle → 15 beats with no loss or duplication, and outputs stable while stalled.
- Reset: assert `async_resetn` low during beat 3 of a frame and while a committed frame is queued → outputs return to their reset values; no beats appear after release until a new frame arrives.
- Filter (`ETH_RX_MAC_FILTER_EN`): `local_mac`=`48'h0605_0403_0201`, `promisc`=0; frames to that address, to broadcast, and to `48'h...AA` → first two pass, third dropped; with `promisc`=1 all three pass.

Source files
------------

// File: rtl/eth_rx_frame_buffer.sv
// rtl/eth_rx_frame_buffer.sv - store-and-forward 64-bit receive frame buffer; optional ETH_RX_MAC_FILTER_EN
module eth_rx_frame_buffer #(
    parameter int DEPTH = 512,
    parameter int CNT_W = 32
) (
    input  logic             clock,
    input  logic             async_resetn,
    input  logic [63:0]      s_axis_tdata,
    input  logic [7:0]       s_axis_tkeep,
    input  logic             s_axis_tlast,
    input  logic             s_axis_tuser,
    input  logic             s_axis_tvalid,
    output logic             s_axis_tready,
    output logic [63:0]      m_axis_tdata,
    output logic [7:0]       m_axis_tkeep,
    output logic             m_axis_tlast,
    output logic             m_axis_tuser,
    output logic             m_axis_tvalid,
    input  logic             m_axis_tready,
    input  logic [47:0]      local_mac,
    input  logic             promisc,
    output logic [CNT_W-1:0] frames_ok,
    output logic [CNT_W-1:0] frames_dropped,
    output logic             drop_pulse
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
    localparam logic [PW-1:0] PTR_ONE = PW'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {S_IDLE, S_RECV, S_DROP} state_t;

    state_t            r_state;
    logic [PW-1:0]     r_wr_ptr;
    logic [PW-1:0]     r_wr_commit;
    logic [PW-1:0]     r_rd_ptr;
    logic [72:0]       r_mem [DEPTH];
    logic [72:0]       r_ram_q;
    logic              r_rd_pend;
    logic              r_v0;
    logic              r_v1;
    logic [72:0]       r_out;
    logic [72:0]       r_skid;
    logic [CNT_W-1:0]  r_frames_ok;
    logic [CNT_W-1:0]  r_frames_dropped;
    logic              r_drop_pulse;

    logic              w_full;
    logic              w_filt_ok;
    logic              w_in_frame;
    logic              w_blocked;
    logic              w_wr_en;
    logic              w_drop;
    logic              w_pop;
    logic [2:0]        w_occ;
    logic              w_rd_en;

    // Full check uses the pre-read rd_ptr, so a same-cycle read never creates false space.
    assign w_full = (r_wr_ptr - r_rd_ptr) == DEPTH_P;

`ifdef ETH_RX_MAC_FILTER_EN
    logic w_addr_ok;
    assign w_addr_ok = promisc || (s_axis_tdata[47:0] == local_mac) ||
                       (s_axis_tdata[47:0] == 48'hFFFF_FFFF_FFFF);
    assign w_filt_ok = (r_state != S_IDLE) || w_addr_ok;
`else
    logic w_unused;
    assign w_unused  = ^{local_mac, promisc};
    assign w_filt_ok = 1'b1;
`endif

    assign w_in_frame = s_axis_tvalid && (r_state != S_DROP);
    assign w_blocked  = w_full || !w_filt_ok;
    assign w_wr_en    = w_in_frame && !w_blocked && !(s_axis_tlast && s_axis_tuser);
    assign w_drop     = s_axis_tvalid && s_axis_tlast &&
                        ((r_state == S_DROP) || (w_in_frame && (w_blocked || s_axis_tuser)));

    always_ff @(posedge clock or negedge async_resetn) begin
        if (!async_resetn) begin
            r_state          <= S_IDLE;
            r_wr_ptr         <= '0;
            r_wr_commit      <= '0;
            r_frames_ok      <= '0;
            r_frames_dropped <= '0;
            r_drop_pulse     <= 1'b0;
        end else begin
            r_drop_pulse <= w_drop;
            if (w_drop) begin
                r_wr_ptr <= r_wr_commit;
                r_state  <= S_IDLE;
                if (r_frames_dropped != '1)
                    r_frames_dropped <= r_frames_dropped + CNT_ONE;
            end else if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
                if (s_axis_tlast) begin
                    r_wr_commit <= r_wr_ptr + PTR_ONE;
                    r_state     <= S_IDLE;
                    if (r_frames_ok != '1)
                        r_frames_ok <= r_frames_ok + CNT_ONE;
                end else begin
                    r_state <= S_RECV;
                end
            end else if (w_in_frame && w_blocked) begin
                r_state <= S_DROP;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (w_wr_en)
            r_mem[r_wr_ptr[AW-1:0]] <= {s_axis_tlast, s_axis_tkeep, s_axis_tdata};
        if (w_rd_en)
            r_ram_q <= r_mem[r_rd_ptr[AW-1:0]];
    end

    // Entries held after this cycle plus the one a new read would land must fit output + skid.
    assign w_pop   = r_v0 && m_axis_tready;
    assign w_occ   = {2'b00, r_v0} + {2'b00, r_v1} + {2'b00, r_rd_pend} - {2'b00, w_pop};
    assign w_rd_en = (r_rd_ptr != r_wr_commit) && (w_occ < 3'd2);

    always_ff @(posedge clock or negedge async_resetn) begin
        if (!async_resetn) begin
            r_rd_ptr  <= '0;
            r_rd_pend <= 1'b0;
            r_v0      <= 1'b0;
            r_v1      <= 1'b0;
            r_out     <= '0;
            r_skid    <= '0;
        end else begin
            r_rd_pend <= w_rd_en;
            if (w_rd_en)
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            if (w_pop || !r_v0) begin
                if (r_v1) begin
                    r_out <= r_skid;
                    r_v0  <= 1'b1;
                    r_v1  <= r_rd_pend;
                    if (r_rd_pend)
                        r_skid <= r_ram_q;
                end else if (r_rd_pend) begin
                    r_out <= r_ram_q;
                    r_v0  <= 1'b1;
                end else begin
                    r_v0 <= 1'b0;
                end
            end else if (r_rd_pend) begin
                r_skid <= r_ram_q;
                r_v1   <= 1'b1;
            end
        end
    end

    assign s_axis_tready  = 1'b1;
    assign m_axis_tdata   = r_out[63:0];
    assign m_axis_tkeep   = r_out[71:64];
    assign m_axis_tlast   = r_out[72];
    assign m_axis_tuser   = 1'b0;
    assign m_axis_tvalid  = r_v0;
    assign frames_ok      = r_frames_ok;
    assign frames_dropped = r_frames_dropped;
    assign drop_pulse     = r_drop_pulse;
endmodule
